combination_acq_sequencer: RTL and testbench

//  Wishbone master that sequences the combination measurement block: configure -> clear -> acquire for N cycles
//  -> stop -> read every bin -> stream {bin, count} on AXI-Stream. Sits beside the combination core on its wb

---
 rtl/combination_acq_sequencer_if.sv | 32 +++
 rtl/combination_acq_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_combination_acq_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/combination_acq_sequencer_if.sv
// Bus bundle for combination_acq_sequencer: Wishbone master port toward the
// combination core and the AXI-Stream result port toward the sink.
interface combination_acq_sequencer_if #(
    parameter int CHANNELS  = 12,
    parameter int ACC_WIDTH = 32
);
    logic [7:0]                    wb_adr_o;
    logic [31:0]                   wb_dat_o;
    logic [31:0]                   wb_dat_i;
    logic                          wb_we_o;
    logic                          wb_stb_o;
    logic                          wb_cyc_o;
    logic                          wb_ack_i;
    logic [CHANNELS+ACC_WIDTH-1:0] m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/combination_acq_sequencer.sv
// Wishbone master sequencing configure/clear/acquire/stop/readout of the combination core,
// streaming {bin, count} on AXI-Stream. Optional ack watchdog: COMB_SEQ_WB_TIMEOUT_EN.
module combination_acq_sequencer #(
    parameter int CHANNELS   = 12,
    parameter int ACC_WIDTH  = 32,
    parameter int DUR_WIDTH  = 32,
    parameter int WB_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            cfg_window,
    input  logic [CHANNELS-1:0]    cfg_mask,
    input  logic [DUR_WIDTH-1:0]   cfg_duration,
    input  logic                   cfg_continuous,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [15:0]            run_count,
    combination_acq_sequencer_if.master bus
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_W_WIN  = 4'd1;
    localparam logic [3:0] S_W_MASK = 4'd2;
    localparam logic [3:0] S_W_CLR  = 4'd3;
    localparam logic [3:0] S_W_RUN  = 4'd4;
    localparam logic [3:0] S_ACQ    = 4'd5;
    localparam logic [3:0] S_W_STOP = 4'd6;
    localparam logic [3:0] S_W_ADDR = 4'd7;
    localparam logic [3:0] S_R_DATA = 4'd8;
    localparam logic [3:0] S_EMIT   = 4'd9;
    localparam logic [3:0] S_DONE   = 4'd10;

    localparam logic [7:0] A_CTRL    = 8'h00;
    localparam logic [7:0] A_WINDOW  = 8'h04;
    localparam logic [7:0] A_MASK    = 8'h08;
    localparam logic [7:0] A_RD_ADDR = 8'h10;
    localparam logic [7:0] A_RD_DATA = 8'h14;

    localparam int TW = CHANNELS + ACC_WIDTH;

    logic [3:0]             state_q, state_d;
    logic                   cyc_q, cyc_d;
    logic [7:0]             adr_q, adr_d;
    logic [31:0]            dat_q, dat_d;
    logic                   we_q, we_d;
    logic                   tvalid_q, tvalid_d;
    logic [TW-1:0]          tdata_q, tdata_d;
    logic                   tlast_q, tlast_d;
    logic [CHANNELS:0]      bin_q, bin_d;
    logic [DUR_WIDTH-1:0]   acq_cnt_q, acq_cnt_d;
    logic [15:0]            window_q, window_d;
    logic [CHANNELS-1:0]    mask_q, mask_d;
    logic [DUR_WIDTH-1:0]   duration_q, duration_d;
    logic                   cont_q, cont_d;
    logic                   abort_pend_q, abort_pend_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [15:0]            run_count_q, run_count_d;

    logic [7:0]             xfer_adr_s;
    logic [31:0]            xfer_dat_s;
    logic                   xfer_we_s;
    logic                   abort_now_s;
    logic [CHANNELS:0]      bin_inc_s;

`ifdef COMB_SEQ_WB_TIMEOUT_EN
    localparam int WDT_W = $clog2(WB_TIMEOUT + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WB_TIMEOUT - 1);
    logic [WDT_W-1:0]       wdt_q, wdt_d;
`else
    logic                   unused_wb_timeout_s;
    assign unused_wb_timeout_s = (WB_TIMEOUT == 0);
`endif

    assign abort_now_s = abort_pend_q | abort;
    assign bin_inc_s   = bin_q + {{CHANNELS{1'b0}}, 1'b1};

    // Address/data/direction of the transfer owned by each bus state.
    always_comb begin
        xfer_adr_s = 8'h00;
        xfer_dat_s = 32'h0000_0000;
        xfer_we_s  = 1'b1;
        case (state_q)
            S_W_WIN:  begin xfer_adr_s = A_WINDOW;  xfer_dat_s = {16'h0000, window_q}; end
            S_W_MASK: begin xfer_adr_s = A_MASK;    xfer_dat_s = 32'(mask_q);          end
            S_W_CLR:  begin xfer_adr_s = A_CTRL;    xfer_dat_s = 32'h0000_0002;        end
            S_W_RUN:  begin xfer_adr_s = A_CTRL;    xfer_dat_s = 32'h0000_0001;        end
            S_W_STOP: begin xfer_adr_s = A_CTRL;    xfer_dat_s = 32'h0000_0000;        end
            S_W_ADDR: begin xfer_adr_s = A_RD_ADDR; xfer_dat_s = 32'(bin_q[CHANNELS-1:0]); end
            S_R_DATA: begin xfer_adr_s = A_RD_DATA; xfer_we_s  = 1'b0;                 end
            default:  begin xfer_adr_s = 8'h00;     xfer_we_s  = 1'b0;                 end
        endcase
    end

    // Sequencer next-state: one Wishbone transfer per bus state, then stream and loop.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        we_d         = we_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        bin_d        = bin_q;
        acq_cnt_d    = acq_cnt_q;
        window_d     = window_q;
        mask_d       = mask_q;
        duration_d   = duration_q;
        cont_d       = cont_q;
        err_d        = err_q;
        run_count_d  = run_count_q;
`ifdef COMB_SEQ_WB_TIMEOUT_EN
        wdt_d        = wdt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    window_d   = cfg_window;
                    mask_d     = cfg_mask;
                    duration_d = cfg_duration;
                    cont_d     = cfg_continuous;
                    err_d      = 1'b0;
                    state_d    = S_W_WIN;
                end else begin
                    state_d    = S_IDLE;
                end
            end

            S_W_WIN, S_W_MASK, S_W_CLR, S_W_RUN, S_W_STOP, S_W_ADDR, S_R_DATA: begin
                if (!cyc_q) begin
                    // A pending abort skips any transfer not yet started, except the stop write.
                    if (abort_now_s && (state_q != S_W_STOP)) begin
                        state_d = S_W_STOP;
                    end else begin
                        cyc_d = 1'b1;
                        adr_d = xfer_adr_s;
                        dat_d = xfer_dat_s;
                        we_d  = xfer_we_s;
`ifdef COMB_SEQ_WB_TIMEOUT_EN
                        wdt_d = {WDT_W{1'b0}};
`endif
                    end
                end else if (bus.wb_ack_i) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    case (state_q)
                        S_W_WIN:  state_d = abort_now_s ? S_W_STOP : S_W_MASK;
                        S_W_MASK: state_d = abort_now_s ? S_W_STOP : S_W_CLR;
                        S_W_CLR:  state_d = abort_now_s ? S_W_STOP : S_W_RUN;
                        S_W_RUN: begin
                            acq_cnt_d = duration_q;
                            if (abort_now_s || (duration_q == {DUR_WIDTH{1'b0}})) begin
                                state_d = S_W_STOP;
                            end else begin
                                state_d = S_ACQ;
                            end
                        end
                        S_W_STOP: begin
                            if (abort_now_s) begin
                                state_d = S_IDLE;
                            end else begin
                                bin_d   = {(CHANNELS+1){1'b0}};
                                state_d = S_W_ADDR;
                            end
                        end
                        S_W_ADDR: state_d = abort_now_s ? S_W_STOP : S_R_DATA;
                        S_R_DATA: begin
                            if (abort_now_s) begin
                                state_d = S_W_STOP;
                            end else begin
                                tvalid_d = 1'b1;
                                tdata_d  = {bin_q[CHANNELS-1:0], bus.wb_dat_i[ACC_WIDTH-1:0]};
                                tlast_d  = bin_inc_s[CHANNELS];
                                state_d  = S_EMIT;
                            end
                        end
                        default:  state_d = S_IDLE;
                    endcase
`ifdef COMB_SEQ_WB_TIMEOUT_EN
                end else if (wdt_q == WDT_LAST) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdt_d   = wdt_q + {{(WDT_W-1){1'b0}}, 1'b1};
                end
`else
                end else begin
                    state_d = state_q;
                end
`endif
            end

            S_ACQ: begin
                if (abort_now_s || (acq_cnt_q == DUR_WIDTH'(1))) begin
                    state_d = S_W_STOP;
                end else begin
                    acq_cnt_d = acq_cnt_q - DUR_WIDTH'(1);
                end
            end

            S_EMIT: begin
                if (bus.m_axis_tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (abort_now_s) begin
                        state_d = S_W_STOP;
                    end else if (bin_inc_s[CHANNELS]) begin
                        state_d = S_DONE;
                    end else begin
                        bin_d   = bin_inc_s;
                        state_d = S_W_ADDR;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end

            S_DONE: begin
                if (cont_q && !abort_now_s) begin
                    state_d = S_W_CLR;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            run_count_d = run_count_q + 16'd1;
        end else begin
            run_count_d = run_count_d;
        end

        done_d       = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
        abort_pend_d = (state_d == S_IDLE) ? 1'b0 : (abort_pend_q | abort);
    end

    // State, bus and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cyc_q        <= 1'b0;
            adr_q        <= 8'h00;
            dat_q        <= 32'h0000_0000;
            we_q         <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= {TW{1'b0}};
            tlast_q      <= 1'b0;
            bin_q        <= {(CHANNELS+1){1'b0}};
            acq_cnt_q    <= {DUR_WIDTH{1'b0}};
            window_q     <= 16'h0000;
            mask_q       <= {CHANNELS{1'b0}};
            duration_q   <= {DUR_WIDTH{1'b0}};
            cont_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            run_count_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            we_q         <= we_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            bin_q        <= bin_d;
            acq_cnt_q    <= acq_cnt_d;
            window_q     <= window_d;
            mask_q       <= mask_d;
            duration_q   <= duration_d;
            cont_q       <= cont_d;
            abort_pend_q <= abort_pend_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            run_count_q  <= run_count_d;
        end
    end

`ifdef COMB_SEQ_WB_TIMEOUT_EN
    // Ack watchdog counter for the transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_q <= {WDT_W{1'b0}};
        end else begin
            wdt_q <= wdt_d;
        end
    end
`endif

    assign bus.wb_adr_o      = adr_q;
    assign bus.wb_dat_o      = dat_q;
    assign bus.wb_we_o       = we_q;
    assign bus.wb_cyc_o      = cyc_q;
    assign bus.wb_stb_o      = cyc_q;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign run_count = run_count_q;

endmodule

// File: tb/tb_combination_acq_sequencer.sv
// Directed bench for combination_acq_sequencer with a 4-bin core model that acks one cycle late.
module tb_combination_acq_sequencer;
    localparam int CH  = 2;
    localparam int ACC = 32;
    localparam int DW  = 32;

    typedef struct {
        logic [7:0]  adr;
        logic        we;
        logic [31:0] dat;
        int          idle;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   cfg_window;
    logic [CH-1:0] cfg_mask;
    logic [DW-1:0] cfg_duration;
    logic          cfg_continuous;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   run_count;

    int n_tests = 0;
    int n_fail  = 0;

    xfer_t            xlog[$];
    logic [CH+ACC-1:0] beats[$];
    logic             lasts[$];
    int               done_cnt = 0;
    int               idle_cnt = 0;
    int               cyc_run = 0;
    int               cyc_hi_len = 0;
    logic             prev_stall = 1'b0;
    logic [CH+ACC-1:0] prev_data;
    logic             noack = 1'b0;
    logic             rnd_ready = 1'b0;
    logic [CH-1:0]    rd_addr_m = '0;

    always #5 clk = ~clk;

    combination_acq_sequencer_if #(.CHANNELS(CH), .ACC_WIDTH(ACC)) bus_if ();

    combination_acq_sequencer #(
        .CHANNELS(CH), .ACC_WIDTH(ACC), .DUR_WIDTH(DW), .WB_TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_window(cfg_window), .cfg_mask(cfg_mask), .cfg_duration(cfg_duration),
        .cfg_continuous(cfg_continuous), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err), .run_count(run_count),
        .bus(bus_if)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core model: ack one cycle after stb, RD_DATA returns a fixed pattern per bin.
    always @(posedge clk) begin
        if (rst) begin
            bus_if.wb_ack_i <= 1'b0;
        end else begin
            bus_if.wb_ack_i <= bus_if.wb_cyc_o && bus_if.wb_stb_o && !bus_if.wb_ack_i && !noack;
            if (bus_if.wb_cyc_o && bus_if.wb_ack_i && bus_if.wb_we_o && bus_if.wb_adr_o == 8'h10)
                rd_addr_m <= bus_if.wb_dat_o[CH-1:0];
        end
    end
    assign bus_if.wb_dat_i = 32'hA5A5_0000 + 32'(rd_addr_m);

    always @(posedge clk) begin
        #1;
        bus_if.m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Bus monitor: transfer log, idle gaps, beats, stall stability, done pulses.
    always @(negedge clk) begin
        if (bus_if.wb_cyc_o && bus_if.wb_ack_i) begin
            xlog.push_back('{adr: bus_if.wb_adr_o, we: bus_if.wb_we_o, dat: bus_if.wb_dat_o, idle: idle_cnt});
            idle_cnt = 0;
        end
        if (!bus_if.wb_cyc_o) idle_cnt++;
        if (bus_if.wb_cyc_o) cyc_run++;
        else begin
            if (cyc_run > 0) cyc_hi_len = cyc_run;
            cyc_run = 0;
        end
        if (prev_stall) begin
            check("hold_tvalid", bus_if.m_axis_tvalid, 1);
            check("hold_tdata", bus_if.m_axis_tdata, prev_data);
        end
        prev_stall = bus_if.m_axis_tvalid && !bus_if.m_axis_tready;
        prev_data  = bus_if.m_axis_tdata;
        if (bus_if.m_axis_tvalid && bus_if.m_axis_tready) begin
            beats.push_back(bus_if.m_axis_tdata);
            lasts.push_back(bus_if.m_axis_tlast);
        end
        if (done) done_cnt++;
    end

    task automatic clear_logs();
        xlog.delete();
        beats.delete();
        lasts.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < budget), 1);
    endtask

    task automatic chk_x(input string tag, input int i, input logic [7:0] adr,
                         input logic we, input logic [31:0] dat);
        check({tag, "_adr"}, xlog[i].adr, adr);
        check({tag, "_we"}, xlog[i].we, we);
        if (we) check({tag, "_dat"}, xlog[i].dat, dat);
    endtask

    task automatic chk_cfg(input string tag, input logic [15:0] win, input logic [CH-1:0] msk, input int stop_idle);
        check({tag, "_nxfer"}, xlog.size(), 13);
        chk_x({tag, "_win"}, 0, 8'h04, 1'b1, {16'h0000, win});
        chk_x({tag, "_mask"}, 1, 8'h08, 1'b1, 32'(msk));
        chk_x({tag, "_clr"}, 2, 8'h00, 1'b1, 32'h2);
        chk_x({tag, "_run"}, 3, 8'h00, 1'b1, 32'h1);
        chk_x({tag, "_stop"}, 4, 8'h00, 1'b1, 32'h0);
        check({tag, "_acq_gap"}, xlog[4].idle, stop_idle);
        for (int b = 0; b < 4; b++) begin
            chk_x({tag, "_rdaddr"}, 5 + 2 * b, 8'h10, 1'b1, 32'(b));
            chk_x({tag, "_rddata"}, 6 + 2 * b, 8'h14, 1'b0, 32'h0);
        end
    endtask

    task automatic chk_beats(input string tag, input int base, input int n);
        logic [CH-1:0] bb;
        for (int b = 0; b < n; b++) begin
            bb = CH'(b);
            check({tag, "_tdata"}, beats[base + b], {bb, 32'hA5A5_0000 + 32'(b)});
            check({tag, "_tlast"}, lasts[base + b], (b == 3));
        end
    endtask

    initial begin
        int n;
        int nlast;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_window = 16'h0; cfg_mask = '0; cfg_duration = '0; cfg_continuous = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_run_count", run_count, 0);
        check("rst_cyc", bus_if.wb_cyc_o, 0);
        check("rst_tvalid", bus_if.m_axis_tvalid, 0);
        check("rst_tlast", bus_if.m_axis_tlast, 0);

        // Single shot, duration 10; a second start mid-run is ignored.
        clear_logs();
        cfg_window = 16'h1234; cfg_mask = 2'b11; cfg_duration = 32'd10;
        pulse_start();
        repeat (3) @(posedge clk);
        cfg_window = 16'hFFFF;
        pulse_start();
        wait_idle("t1_finish", 1000);
        chk_cfg("t1", 16'h1234, 2'b11, 11);
        check("t1_nbeats", beats.size(), 4);
        chk_beats("t1", 0, 4);
        check("t1_done", done_cnt, 1);
        check("t1_run_count", run_count, 1);

        // Random back-pressure during readout.
        clear_logs();
        rnd_ready = 1'b1;
        cfg_window = 16'h00FF; cfg_mask = 2'b01; cfg_duration = 32'd3;
        pulse_start();
        wait_idle("t2_finish", 1000);
        rnd_ready = 1'b0;
        chk_cfg("t2", 16'h00FF, 2'b01, 4);
        check("t2_nbeats", beats.size(), 4);
        chk_beats("t2", 0, 4);
        check("t2_run_count", run_count, 2);

        // Zero duration: run and stop back to back.
        clear_logs();
        cfg_duration = 32'd0;
        pulse_start();
        wait_idle("t3_finish", 1000);
        chk_cfg("t3", 16'h00FF, 2'b01, 1);
        check("t3_nbeats", beats.size(), 4);
        chk_beats("t3", 0, 4);
        check("t3_run_count", run_count, 3);

        // Abort during acquire.
        clear_logs();
        cfg_duration = 32'd20;
        pulse_start();
        n = 0;
        while (xlog.size() < 4 && n < 500) begin @(negedge clk); n++; end
        check("t4_reach_acq", (n < 500), 1);
        repeat (5) @(posedge clk);
        pulse_abort();
        wait_idle("t4_finish", 1000);
        check("t4_nxfer", xlog.size(), 5);
        chk_x("t4_stop", 4, 8'h00, 1'b1, 32'h0);
        check("t4_nbeats", beats.size(), 0);
        check("t4_done", done_cnt, 0);
        check("t4_busy", busy, 0);
        check("t4_run_count", run_count, 3);

        // Continuous: three runs, abort in readout of the fourth after bin 0.
        clear_logs();
        cfg_duration = 32'd2; cfg_continuous = 1'b1;
        pulse_start();
        n = 0;
        while (beats.size() < 13 && n < 3000) begin @(negedge clk); n++; end
        check("t5_reach_run4", (n < 3000), 1);
        pulse_abort();
        wait_idle("t5_finish", 1000);
        cfg_continuous = 1'b0;
        check("t5_run_count", run_count, 6);
        check("t5_done", done_cnt, 3);
        check("t5_nbeats", beats.size(), 13);
        chk_beats("t5_run3", 8, 4);
        check("t5_partial_tdata", beats[12], {2'b00, 32'hA5A5_0000});
        check("t5_partial_tlast", lasts[12], 0);
        nlast = 0;
        foreach (lasts[i]) if (lasts[i]) nlast++;
        check("t5_ntlast", nlast, 3);
        chk_x("t5_rerun_clr", 13, 8'h00, 1'b1, 32'h2);
        chk_x("t5_rerun_run", 14, 8'h00, 1'b1, 32'h1);
        chk_x("t5_final_stop", xlog.size() - 1, 8'h00, 1'b1, 32'h0);

        // start and abort in the same idle cycle: start ignored.
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_cyc", bus_if.wb_cyc_o, 0);

`ifdef COMB_SEQ_WB_TIMEOUT_EN
        // Slave never acks: watchdog drops the cycle and flags err.
        clear_logs();
        noack = 1'b1;
        pulse_start();
        wait_idle("t7_finish", 1000);
        check("t7_err", err, 1);
        check("t7_cyc_len", cyc_hi_len, 255);
        check("t7_done", done_cnt, 0);
        check("t7_run_count", run_count, 6);
        noack = 1'b0;
        cfg_duration = 32'd1;
        pulse_start();
        @(negedge clk);
        check("t7_err_cleared", err, 0);
        wait_idle("t7_rerun", 1000);
        check("t7_rerun_count", run_count, 7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end
endmodule
